// File: rtl/register_file_multiport.sv
// Multi-port general-purpose register file: NUM_RD combinational read ports, one
// synchronous write port, optional hard-wired zero entry, write-to-read bypass and a reset clear sweep.
module register_file_multiport #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REG_W_En,
    input  logic [ADDR_W-1:0]        REG_W_Addr,
    input  logic [DATA_W-1:0]        REG_W_Data,
    input  logic [NUM_RD*ADDR_W-1:0] REG_R_Addr,
    output logic [NUM_RD*DATA_W-1:0] REG_R_Data,
    output logic                     REG_Busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic [ADDR_W-1:0]   clr_cnt_s;
    logic                wr_commit_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // An address that is out of range or names the hard-wired zero entry never stores data.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_W) && !((ZERO_R0 != 0) && (addr == '0));
    endfunction

    // State and sweep-counter register; reset always restarts the sweep from entry 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
        end
    end

    // Next-state logic, busy flag and write qualification.
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_s = ST_READY;
                end else begin
                    clr_cnt_s = clr_cnt_r + ONE_IDX;
                end
            end
            ST_READY: begin
                state_s = ST_READY;
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_cnt_s = '0;
            end
        endcase
        REG_Busy    = (state_r != ST_READY);
        wr_commit_s = (state_r == ST_READY) && !RST && REG_W_En && addr_valid(REG_W_Addr);
    end

    // Storage: the sweep zeroes one entry per cycle, otherwise a qualified write lands.
    always_ff @(posedge CLK) begin
        if (!RST && (state_r == ST_CLEAR)) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_commit_s) begin
            mem_r[REG_W_Addr] <= REG_W_Data;
        end
    end

    // Read ports: zero while sweeping or for invalid addresses, then bypass, then storage.
    always_comb begin
        logic [ADDR_W-1:0] rd_addr_s;
        rd_addr_s  = '0;
        REG_R_Data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_s = REG_R_Addr[p*ADDR_W +: ADDR_W];
            if ((state_r != ST_READY) || !addr_valid(rd_addr_s)) begin
                REG_R_Data[p*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_commit_s && (rd_addr_s == REG_W_Addr)) begin
                REG_R_Data[p*DATA_W +: DATA_W] = REG_W_Data;
            end else begin
                REG_R_Data[p*DATA_W +: DATA_W] = mem_r[rd_addr_s];
            end
        end
    end

endmodule
